// File: rtl/spi_xfer_scheduler_if.sv
// Request/completion handshake plus the APB master bus of the SPI transfer scheduler.
// Pass-through bundle: no logic, no latency; flow control is owned by the endpoints.
interface spi_xfer_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*3-1:0]  req_len_i;
    logic [NUM_REQ*40-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    done_o;
    logic                  err_o;
    logic                  busy_o;
    logic [7:0]            paddr_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [7:0]            pwdata_o;
    logic                  pready_i;
    logic                  prdata_i;

    // master: the scheduler itself (it is the APB master towards the SPI block)
    modport master (
        input  req_valid_i, req_len_i, req_data_i, pready_i, prdata_i,
        output req_ready_o, done_o, err_o, busy_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );

    // slave: clients plus the SPI master's APB slave port
    modport slave (
        output req_valid_i, req_len_i, req_data_i, pready_i, prdata_i,
        input  req_ready_o, done_o, err_o, busy_o,
               paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );
endinterface

// File: rtl/spi_xfer_scheduler.sv
// Round-robin shares one APB-programmed SPI master: load bytes, LEN, start, then poll STATUS.
// Latency: grant one cycle after valid; requesters hold valid until ready; APB waits on pready_i.
module spi_xfer_scheduler #(
    parameter int         NUM_REQ   = 2,
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         POLL_GAP  = 4,
    parameter int         POLL_MAX  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spi_xfer_scheduler_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_POLL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0]  POLL_LAST = 8'(POLL_MAX - 1);
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

    logic [2:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner;
    logic [2:0]         len_q;
    logic [39:0]        data_q;
    logic [2:0]         op;
    logic               rd_q;
    logic               err_q;
    logic [7:0]         poll_cnt;
    logic [15:0]        gap_cnt;
    logic [NUM_REQ-1:0] ready_q;

    logic               found;
    logic [PW-1:0]      win;
    logic [2:0]         win_len;
    logic [39:0]        win_data;
    logic               win_legal;
    int                 idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid_i[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign win_len   = bus.req_len_i[int'(win)*3 +: 3];
    assign win_data  = bus.req_data_i[int'(win)*40 +: 40];
    assign win_legal = (win_len >= 3'd1) && (win_len <= 3'd5);

    // Op index walks DATA[0..len-1], then LEN (op==len), then CTRL (op==len+1).
    logic [7:0] cur_byte;
    logic [7:0] wr_addr;
    logic [7:0] wr_dat;

    always_comb begin
        case (op)
            3'd0:    cur_byte = data_q[7:0];
            3'd1:    cur_byte = data_q[15:8];
            3'd2:    cur_byte = data_q[23:16];
            3'd3:    cur_byte = data_q[31:24];
            default: cur_byte = data_q[39:32];
        endcase
        if (op < len_q) begin
            wr_addr = BASE_ADDR + {5'd0, op};
            wr_dat  = cur_byte;
        end else if (op == len_q) begin
            wr_addr = BASE_ADDR + 8'd5;
            wr_dat  = {5'd0, len_q};
        end else begin
            wr_addr = BASE_ADDR + 8'd6;
            wr_dat  = 8'h01;
        end
    end

    logic psel;
    logic done_any;

    assign psel          = (state == S_SETUP) || (state == S_ACCESS);
    assign bus.psel_o    = psel;
    assign bus.penable_o = (state == S_ACCESS);
    assign bus.pwrite_o  = psel && !rd_q;
    assign bus.paddr_o   = !psel ? 8'h00 : (rd_q ? BASE_ADDR + 8'd7 : wr_addr);
    assign bus.pwdata_o  = (psel && !rd_q) ? wr_dat : 8'h00;
    assign bus.busy_o    = (state != S_IDLE);
    assign bus.req_ready_o = ready_q;

    // An illegal command reaches DONE while its ready pulse is still up; hold done back one cycle.
    assign done_any   = (state == S_DONE) && (ready_q == '0);
    assign bus.done_o = done_any ? (NUM_REQ'(1) << owner) : '0;
    assign bus.err_o  = done_any && err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            ptr      <= '0;
            owner    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            op       <= '0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            ready_q  <= '0;
        end else begin
            ready_q <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner    <= win;
                        len_q    <= win_len;
                        data_q   <= win_data;
                        op       <= '0;
                        rd_q     <= 1'b0;
                        poll_cnt <= '0;
                        gap_cnt  <= '0;
                        err_q    <= !win_legal;
                        ready_q  <= NUM_REQ'(1) << win;
                        if (int'(win) == NUM_REQ - 1) ptr <= '0;
                        else                          ptr <= win + 1'b1;
                        state    <= win_legal ? S_SETUP : S_DONE;
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: begin
                    if (bus.pready_i) begin
                        if (!rd_q) begin
                            if (op == len_q + 3'd1) begin
                                rd_q    <= 1'b1;
                                gap_cnt <= '0;
                                state   <= (POLL_GAP == 0) ? S_SETUP : S_POLL;
                            end else begin
                                op    <= op + 3'd1;
                                state <= S_SETUP;
                            end
                        end else if (!bus.prdata_i) begin
                            err_q <= 1'b0;
                            state <= S_DONE;
                        end else if (poll_cnt == POLL_LAST) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            poll_cnt <= poll_cnt + 8'd1;
                            gap_cnt  <= '0;
                            state    <= (POLL_GAP == 0) ? S_SETUP : S_POLL;
                        end
                    end
                end
                S_POLL: begin
                    if (gap_cnt == GAP_LAST) state <= S_SETUP;
                    else                     gap_cnt <= gap_cnt + 16'd1;
                end
                S_DONE: begin
                    if (ready_q == '0) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench: vector table for single commands plus hand sequences for arbitration and reset.
// An APB slave model answers with configurable wait states and STATUS busy responses.
module tb_spi_xfer_scheduler;
    localparam int NUM_REQ  = 2;
    localparam int POLL_GAP = 4;
    localparam int POLL_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    spi_xfer_scheduler #(
        .NUM_REQ(NUM_REQ), .BASE_ADDR(8'h00), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // slave model configuration (written by the stimulus only)
    int wait_cfg = 0;
    int busy_cfg = 0;
    int rd_base  = 0;

    // monitor state (written by the monitor only)
    int         cyc = 0;
    int         acc_cnt = 0;
    int         nlog = 0;
    logic [7:0] log_addr [256];
    logic       log_wr   [256];
    logic [7:0] log_dat  [256];
    int         nrd = 0;
    int         gap_log  [256];
    int         idle_run = 0;
    int         acc_bad = 0, stab_bad = 0, ready_bad = 0, err_bad = 0;
    int         psel_cnt = 0;
    logic [7:0] s_addr, s_dat;
    logic       s_wr;
    int         ngrant = 0;
    int         grant_log [64];
    int         ready_cyc = 0;
    int         done_cnt = 0, done_owner = 0, done_cyc = 0;
    logic       done_err = 1'b0;
    logic       chk_busy = 1'b0;
    logic       busy_after = 1'b1;
    logic [NUM_REQ-1:0] prev_ready = '0;

    initial begin
        bus.pready_i = 1'b0;
        bus.prdata_i = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.psel_o && bus.penable_o) begin
            bus.pready_i = (acc_cnt >= wait_cfg);
            bus.prdata_i = !bus.pwrite_o && ((nrd - rd_base) < busy_cfg);
            if (bus.paddr_o != s_addr || bus.pwdata_o != s_dat || bus.pwrite_o != s_wr)
                stab_bad++;
            acc_cnt++;
            if (bus.pready_i) begin
                if (acc_cnt != wait_cfg + 1) acc_bad++;
                if (nlog < 256) begin
                    log_addr[nlog] = bus.paddr_o;
                    log_wr[nlog]   = bus.pwrite_o;
                    log_dat[nlog]  = bus.pwdata_o;
                    nlog++;
                end
                if (!bus.pwrite_o) nrd++;
            end
        end else begin
            bus.pready_i = 1'b0;
            bus.prdata_i = 1'b0;
            acc_cnt = 0;
        end
        if (bus.psel_o && !bus.penable_o) begin
            s_addr = bus.paddr_o;
            s_dat  = bus.pwdata_o;
            s_wr   = bus.pwrite_o;
            psel_cnt++;
            if (!bus.pwrite_o && nrd < 256) gap_log[nrd] = idle_run;
            idle_run = 0;
        end
        if (bus.busy_o && !bus.psel_o) idle_run++;
        if (bus.req_ready_o != '0) begin
            if ($countones(bus.req_ready_o) != 1 || prev_ready != '0) ready_bad++;
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_ready_o[i] && ngrant < 64) grant_log[ngrant] = i;
            ngrant++;
            ready_cyc = cyc;
        end
        prev_ready = bus.req_ready_o;
        if (bus.err_o && bus.done_o == '0) err_bad++;
        if (bus.done_o != '0) begin
            done_cnt++;
            done_err = bus.err_o;
            done_cyc = cyc;
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.done_o[i]) done_owner = i;
            chk_busy = 1'b1;
        end else if (chk_busy) begin
            busy_after = bus.busy_o;
            chk_busy = 1'b0;
        end
    end

    typedef struct {
        int         idx;
        logic [2:0] len;
        logic [39:0] data;
        int         wt;
        int         bz;
        int         exp_wr;
        int         exp_rd;
        logic       exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int lb, db, pb, ab, sb, gb, got, to, nw, nr, bad, j;
        int rem [NUM_REQ];
        logic [39:0] d;

        // idx len data wait busy_reads exp_writes exp_reads exp_err
        vt[0] = '{0, 3'd1, 40'h00000000A5,   0, 0,   3, 1, 1'b0};
        vt[1] = '{1, 3'd5, 40'h5544332211,   2, 0,   7, 1, 1'b0};
        vt[2] = '{0, 3'd2, 40'h000000BEEF,   0, 2,   4, 3, 1'b0};
        vt[3] = '{1, 3'd3, 40'h0000C0FFEE,   1, 255, 5, 3, 1'b1};
        vt[4] = '{0, 3'd0, 40'h0000000077,   0, 0,   0, 0, 1'b1};
        vt[5] = '{1, 3'd6, 40'h0000000088,   0, 0,   0, 0, 1'b1};
        vt[6] = '{0, 3'd4, 40'h0004030201,   0, 1,   6, 2, 1'b0};

        bus.req_valid_i = '0;
        bus.req_len_i   = '0;
        bus.req_data_i  = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_psel",    bus.psel_o, 0);
        chk("rst_penable", bus.penable_o, 0);
        chk("rst_busy",    bus.busy_o, 0);
        chk("rst_ready",   bus.req_ready_o, 0);
        chk("rst_done",    bus.done_o, 0);
        chk("rst_err",     bus.err_o, 0);
        chk("rst_bus",     {bus.paddr_o, bus.pwdata_o, bus.pwrite_o}, 0);
        rst = 1'b0;
        tick();

        // both requesters twice, re-raising valid on own completion
        wait_cfg = 0; busy_cfg = 0; rd_base = nrd;
        gb = ngrant; db = done_cnt;
        bus.req_len_i  = {3'd1, 3'd1};
        bus.req_data_i = {40'h00000000B1, 40'h00000000A0};
        rem[0] = 2; rem[1] = 2;
        bus.req_valid_i = 2'b11;
        for (int c = 0; c < 3000 && (ngrant - gb < 4 || done_cnt - db < 4); c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready_o[i]) begin
                    bus.req_valid_i[i] = 1'b0;
                    rem[i]--;
                end
                if (bus.done_o[i] && rem[i] > 0) bus.req_valid_i[i] = 1'b1;
            end
            rd_base = nrd;
        end
        bus.req_valid_i = '0;
        chk("rr_grants", ngrant - gb, 4);
        chk("rr_dones",  done_cnt - db, 4);
        chk("rr_g0", grant_log[gb],     0);
        chk("rr_g1", grant_log[gb + 1], 1);
        chk("rr_g2", grant_log[gb + 2], 0);
        chk("rr_g3", grant_log[gb + 3], 1);
        repeat (2) tick();

        for (int n = 0; n < NV; n++) begin
            wait_cfg = vt[n].wt; busy_cfg = vt[n].bz; rd_base = nrd;
            lb = nlog; db = done_cnt; pb = psel_cnt; ab = acc_bad; sb = stab_bad;
            bus.req_len_i[vt[n].idx*3 +: 3]   = vt[n].len;
            bus.req_data_i[vt[n].idx*40 +: 40] = vt[n].data;
            bus.req_valid_i[vt[n].idx] = 1'b1;
            got = 0;
            for (int c = 0; c < 50 && got == 0; c++) begin
                tick();
                if (bus.req_ready_o[vt[n].idx]) got = 1;
            end
            bus.req_valid_i[vt[n].idx] = 1'b0;
            chk($sformatf("v%0d_ready", n), got, 1);
            to = 1;
            for (int c = 0; c < 600 && to == 1; c++) begin
                if (done_cnt != db) to = 0;
                else tick();
            end
            chk($sformatf("v%0d_done_timeout", n), to, 0);
            repeat (2) tick();
            chk($sformatf("v%0d_done_count", n), done_cnt - db, 1);
            chk($sformatf("v%0d_owner", n), done_owner, vt[n].idx);
            chk($sformatf("v%0d_err", n), done_err, vt[n].exp_err);
            chk($sformatf("v%0d_busy_after_done", n), busy_after, 0);
            nw = 0; nr = 0;
            for (int k = lb; k < nlog; k++) begin
                if (log_wr[k]) nw++;
                else nr++;
            end
            chk($sformatf("v%0d_writes", n), nw, vt[n].exp_wr);
            chk($sformatf("v%0d_reads", n), nr, vt[n].exp_rd);
            bad = 0; j = lb; d = vt[n].data;
            if (vt[n].exp_wr > 0) begin
                for (int i = 0; i < int'(vt[n].len); i++) begin
                    if (j < nlog && (log_addr[j] != 8'(i) || !log_wr[j] || log_dat[j] != d[i*8 +: 8])) bad++;
                    j++;
                end
                if (j < nlog && (log_addr[j] != 8'h05 || !log_wr[j] || log_dat[j] != {5'd0, vt[n].len})) bad++;
                j++;
                if (j < nlog && (log_addr[j] != 8'h06 || !log_wr[j] || log_dat[j] != 8'h01)) bad++;
                j++;
                for (int r = 0; r < vt[n].exp_rd; r++) begin
                    if (j < nlog && (log_addr[j] != 8'h07 || log_wr[j] || log_dat[j] != 8'h00)) bad++;
                    j++;
                end
            end
            chk($sformatf("v%0d_apb_content", n), bad, 0);
            bad = 0;
            for (int r = rd_base; r < nrd; r++)
                if (gap_log[r] != POLL_GAP) bad++;
            chk($sformatf("v%0d_poll_gap", n), bad, 0);
            chk($sformatf("v%0d_access_len", n), acc_bad - ab, 0);
            chk($sformatf("v%0d_addr_data_stable", n), stab_bad - sb, 0);
            if (vt[n].exp_wr == 0) begin
                chk($sformatf("v%0d_no_psel", n), psel_cnt - pb, 0);
                chk($sformatf("v%0d_done_after_ready", n), done_cyc - ready_cyc, 1);
            end
        end

        // reset in the middle of a stretched ACCESS
        wait_cfg = 30; busy_cfg = 0; rd_base = nrd;
        bus.req_len_i[2:0]  = 3'd5;
        bus.req_data_i[39:0] = 40'h0A0B0C0D0E;
        bus.req_valid_i[0] = 1'b1;
        got = 0;
        for (int c = 0; c < 50 && got == 0; c++) begin
            tick();
            if (bus.psel_o && bus.penable_o) got = 1;
            if (bus.req_ready_o[0]) bus.req_valid_i[0] = 1'b0;
        end
        bus.req_valid_i = '0;
        chk("abort_reached_access", got, 1);
        db = done_cnt;
        rst = 1'b1;
        tick();
        chk("abort_psel",    bus.psel_o, 0);
        chk("abort_penable", bus.penable_o, 0);
        chk("abort_busy",    bus.busy_o, 0);
        tick();
        rst = 1'b0;
        wait_cfg = 0;
        repeat (20) tick();
        chk("abort_no_done", done_cnt - db, 0);

        // pointer back at 0 after reset
        bus.req_len_i  = {3'd1, 3'd1};
        bus.req_valid_i = 2'b11;
        got = 0;
        for (int c = 0; c < 50 && got == 0; c++) begin
            tick();
            if (bus.req_ready_o != '0) got = 1;
        end
        chk("post_reset_grant", bus.req_ready_o, 2'b01);
        bus.req_valid_i = '0;
        db = done_cnt;
        to = 1;
        for (int c = 0; c < 600 && to == 1; c++) begin
            if (done_cnt != db) to = 0;
            else tick();
        end
        chk("post_reset_done_timeout", to, 0);
        repeat (3) tick();
        chk("ready_pulse_shape", ready_bad, 0);
        chk("err_without_done", err_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
